// File: rtl/led_matrix_pkg.sv
// Shared types and elaboration helpers for the LED matrix PWM scan driver.
package led_matrix_pkg;

  // Each row slot is a dark blanking interval followed by the PWM on-time.
  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_ON    = 1'b1
  } phase_t;

  // Default geometry of the LED FeatherWing board (6x6, columns sink current).
  localparam int FW_ROWS        = 6;
  localparam int FW_COLS        = 6;
  localparam int FW_COL_ACT_LOW = 1;

  // Number of bits needed to count 0..value-1 (0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_frame_dbuf.sv
// Double-buffered pixel store: one bank is on display (front) while the
// other (back) accepts pixel writes; a swap exchanges their roles.
module led_frame_dbuf
  import led_matrix_pkg::*;
#(
  parameter int ROWS = FW_ROWS,
  parameter int COLS = FW_COLS,
  parameter int BPP  = 4,
  parameter int AW   = clog2(ROWS * COLS),
  parameter int RW   = max2(1, clog2(ROWS))
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [BPP-1:0]      wr_data,
  input  logic                swap,
  input  logic [RW-1:0]       rd_row,
  output logic [COLS*BPP-1:0] rd_data
);

  localparam int NPIX = ROWS * COLS;

  logic           front_sel;
  logic [BPP-1:0] bank0 [NPIX];
  logic [BPP-1:0] bank1 [NPIX];
  logic           wr_ok;
  logic [AW-1:0]  rd_idx;

  assign wr_ok = wr_en && (int'(wr_addr) < NPIX);

  // Front select flips on every committed swap; bank 0 is on display after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front_sel <= 1'b0;
    end else if (swap) begin
      front_sel <= ~front_sel;
    end
  end

  // Writes go to the bank not on display, judged before a same-edge swap, so they join the committed frame.
  always_ff @(posedge clk) begin
    if (wr_ok && front_sel) begin
      bank0[wr_addr] <= wr_data;
    end
    if (wr_ok && !front_sel) begin
      bank1[wr_addr] <= wr_data;
    end
  end

  // The whole front row is read at once so every column comparator sees its pixel in parallel.
  always_comb begin
    rd_data = '0;
    rd_idx  = '0;
    for (int c = 0; c < COLS; c++) begin
      rd_idx = AW'(int'(rd_row) * COLS + c);
      rd_data[c*BPP +: BPP] = front_sel ? bank1[rd_idx] : bank0[rd_idx];
    end
  end

endmodule

// File: rtl/led_matrix_pwm_scan.sv
// Row-scanned LED matrix driver with per-pixel PWM grayscale, row blanking
// against ghosting and a tear-free frame buffer swap at frame end.
module led_matrix_pwm_scan
  import led_matrix_pkg::*;
#(
  parameter int ROWS         = FW_ROWS,
  parameter int COLS         = FW_COLS,
  parameter int BPP          = 4,
  parameter int TICK_DIV     = 16,
  parameter int BLANK_CYCLES = 8,
  parameter int COL_ACT_LOW  = FW_COL_ACT_LOW
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        wr_en,
  input  logic [clog2(ROWS*COLS)-1:0] wr_addr,
  input  logic [BPP-1:0]              wr_data,
  input  logic                        swap_req,
  output logic                        swap_pend,
  output logic                        swap_done,
  output logic                        frame_start,
  output logic [ROWS-1:0]             row,
  output logic [COLS-1:0]             col
);

  localparam int AW = clog2(ROWS * COLS);
  localparam int RW = max2(1, clog2(ROWS));
  localparam int CW = max2(1, clog2(max2(TICK_DIV, BLANK_CYCLES)));

  localparam logic [CW-1:0]   BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0]   TICK_LAST  = CW'(TICK_DIV - 1);
  localparam logic [BPP-1:0]  STEP_LAST  = BPP'((1 << BPP) - 2);
  localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS - 1);
  localparam logic [COLS-1:0] COL_OFF    = {COLS{COL_ACT_LOW != 0}};

  phase_t               phase;
  logic [RW-1:0]        row_idx;
  logic [CW-1:0]        cyc_cnt;
  logic [BPP-1:0]       step_cnt;
  logic [COLS*BPP-1:0]  front_row;
  logic [COLS-1:0]      lit;
  logic [ROWS-1:0]      row_sel;
  logic                 step_end;
  logic                 frame_end;
  logic                 do_swap;
  logic                 frame_first;

  led_frame_dbuf #(
    .ROWS (ROWS),
    .COLS (COLS),
    .BPP  (BPP),
    .AW   (AW),
    .RW   (RW)
  ) u_dbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .swap    (do_swap),
    .rd_row  (row_idx),
    .rd_data (front_row)
  );

  assign step_end    = (phase == PH_ON) && (cyc_cnt == TICK_LAST);
  assign frame_end   = en && step_end && (step_cnt == STEP_LAST) && (row_idx == ROW_LAST);
  assign do_swap     = frame_end && swap_pend;
  assign frame_first = en && (phase == PH_BLANK) && (row_idx == '0) && (cyc_cnt == '0);
  assign row_sel     = ROWS'(1) << row_idx;

  // A column is lit while its pixel value exceeds the current PWM step, so 0 never lights and full scale always does.
  always_comb begin
    lit = '0;
    for (int c = 0; c < COLS; c++) begin
      lit[c] = front_row[c*BPP +: BPP] > step_cnt;
    end
  end

  // Scan sequencer: BLANK then ON steps per row, rows wrap; disabling parks it at row 0 BLANK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= PH_BLANK;
      row_idx  <= '0;
      cyc_cnt  <= '0;
      step_cnt <= '0;
    end else if (!en) begin
      phase    <= PH_BLANK;
      row_idx  <= '0;
      cyc_cnt  <= '0;
      step_cnt <= '0;
    end else if (phase == PH_BLANK) begin
      if (cyc_cnt == BLANK_LAST) begin
        phase    <= PH_ON;
        cyc_cnt  <= '0;
        step_cnt <= '0;
      end else begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end
    end else if (step_end) begin
      cyc_cnt <= '0;
      if (step_cnt == STEP_LAST) begin
        phase    <= PH_BLANK;
        step_cnt <= '0;
        row_idx  <= (row_idx == ROW_LAST) ? '0 : row_idx + 1'b1;
      end else begin
        step_cnt <= step_cnt + 1'b1;
      end
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
    end
  end

  // Swap bookkeeping: a request waits for frame end; a request arriving on the swap edge arms the next swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_pend <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      swap_done <= do_swap;
      if (do_swap) begin
        swap_pend <= swap_req;
      end else if (swap_req) begin
        swap_pend <= 1'b1;
      end
    end
  end

  // Registered pin drive: rows and columns dark unless enabled and in the ON phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row         <= '0;
      col         <= COL_OFF;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_first;
      if (en && (phase == PH_ON)) begin
        row <= row_sel;
        col <= lit ^ COL_OFF;
      end else begin
        row <= '0;
        col <= COL_OFF;
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_pwm_scan.sv
// Scoreboard bench for led_matrix_pwm_scan: a frame-position reference model
// predicts every output cycle into a queue and a monitor compares on negedge.
module tb_led_matrix_pwm_scan;

  localparam int ROWS         = 6;
  localparam int COLS         = 6;
  localparam int BPP          = 2;
  localparam int TICK_DIV     = 2;
  localparam int BLANK_CYCLES = 2;
  localparam int COL_ACT_LOW  = 1;
  localparam int NPIX         = ROWS * COLS;
  localparam int NSTEPS       = (1 << BPP) - 1;
  localparam int ROW_CLK      = BLANK_CYCLES + NSTEPS * TICK_DIV;
  localparam int FRAME_CLK    = ROWS * ROW_CLK;

  typedef struct packed {
    logic [ROWS-1:0] row;
    logic [COLS-1:0] col;
    logic [COLS-1:0] mask;
    logic            fs;
    logic            done;
    logic            pend;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic            en;
  logic            wr_en;
  logic [5:0]      wr_addr;
  logic [BPP-1:0]  wr_data;
  logic            swap_req;
  logic            swap_pend;
  logic            swap_done;
  logic            frame_start;
  logic [ROWS-1:0] row;
  logic [COLS-1:0] col;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   mon_cycle    = 0;
  exp_t exp_q[$];

  // Reference model state: position in the frame, pending flag, which buffer is shown, pixel contents.
  int   m_pos   = 0;
  bit   m_pend  = 0;
  int   m_front = 0;
  int   m_mem   [2][NPIX];
  bit   m_known [2][NPIX];
  int   m_r, m_w, m_s, m_p;
  exp_t m_e;
  exp_t mon_e;
  int   gray [COLS] = '{0, 1, 2, 3, 3, 0};
  int   dark = 0;

  led_matrix_pwm_scan #(
    .ROWS         (ROWS),
    .COLS         (COLS),
    .BPP          (BPP),
    .TICK_DIV     (TICK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .COL_ACT_LOW  (COL_ACT_LOW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
    .swap_pend   (swap_pend),
    .swap_done   (swap_done),
    .frame_start (frame_start),
    .row         (row),
    .col         (col)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: predict what the pins show after this edge from frame position arithmetic.
  always @(posedge clk) begin
    m_e.row  = '0;
    m_e.col  = '1;
    m_e.mask = '1;
    m_e.fs   = 1'b0;
    m_e.done = 1'b0;
    if (!rst_n) begin
      m_pos   = 0;
      m_pend  = 0;
      m_front = 0;
    end else begin
      if (en) begin
        m_r = m_pos / ROW_CLK;
        m_w = m_pos % ROW_CLK;
        if (m_w < BLANK_CYCLES) begin
          m_e.fs = (m_pos == 0);
        end else begin
          m_s = (m_w - BLANK_CYCLES) / TICK_DIV;
          m_e.row[m_r] = 1'b1;
          for (int c = 0; c < COLS; c++) begin
            m_p = m_r * COLS + c;
            if (!m_known[m_front][m_p]) m_e.mask[c] = 1'b0;
            m_e.col[c] = !(m_mem[m_front][m_p] > m_s);
          end
        end
      end
      if (wr_en && int'(wr_addr) < NPIX) begin
        m_mem[1 - m_front][wr_addr]   = int'(wr_data);
        m_known[1 - m_front][wr_addr] = 1'b1;
      end
      if (en && m_pos == FRAME_CLK - 1 && m_pend) begin
        m_front  = 1 - m_front;
        m_e.done = 1'b1;
        m_pend   = swap_req;
      end else if (swap_req) begin
        m_pend = 1'b1;
      end
      m_pos = en ? (m_pos + 1) % FRAME_CLK : 0;
    end
    m_e.pend = m_pend;
    exp_q.push_back(m_e);
  end

  // Monitor: pop one prediction per cycle and compare against the pins mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput(mon_e);
    end
    mon_cycle++;
  end

  task automatic checkOutput(input exp_t e);
    logic [ROWS+COLS+2:0] act_v;
    logic [ROWS+COLS+2:0] exp_v;
    act_v = {row, col & e.mask, frame_start, swap_done, swap_pend};
    exp_v = {e.row, e.col & e.mask, e.fs, e.done, e.pend};
    tests_run++;
    if (act_v !== exp_v) begin
      tests_failed++;
      $display("[TB] FAIL pins@cycle%0d: got row=%b col=%b fs=%b done=%b pend=%b, want row=%b col=%b fs=%b done=%b pend=%b (col mask %b)",
               mon_cycle, row, col, frame_start, swap_done, swap_pend,
               e.row, e.col, e.fs, e.done, e.pend, e.mask);
    end
  endtask

  // Drive inputs for the coming edge, then return just after the following negedge.
  task automatic applyStimulus(input logic e, input logic we, input logic [5:0] a,
                               input logic [BPP-1:0] d, input logic sr);
    en       = e;
    wr_en    = we;
    wr_addr  = a;
    wr_data  = d;
    swap_req = sr;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input logic e, input int n);
    for (int i = 0; i < n; i++) applyStimulus(e, 1'b0, 6'd0, '0, 1'b0);
  endtask

  // Run with the display on until the next edge is at frame position p.
  task automatic waitPos(input int p);
    int guard;
    guard = 0;
    while (m_pos != p && guard < 4 * FRAME_CLK) begin
      applyStimulus(1'b1, 1'b0, 6'd0, '0, 1'b0);
      guard++;
    end
    if (m_pos != p) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL waitPos: got position %0d, want %0d", m_pos, p);
    end
  endtask

  task automatic doReset(input int n, input logic en_after);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) applyStimulus(en_after, 1'b0, 6'd0, '0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    swap_req = 1'b0;
    @(negedge clk);
    #1;
    idle(1'b0, 3);
    rst_n = 1'b1;

    // Fill the back buffer while dark, request a swap and confirm it waits for an enabled frame end.
    for (int i = 0; i < NPIX; i++) applyStimulus(1'b0, 1'b1, 6'(i), BPP'($urandom), 1'b0);
    applyStimulus(1'b0, 1'b0, 6'd0, '0, 1'b1);
    idle(1'b0, 3);
    idle(1'b1, FRAME_CLK + 4);
    for (int i = 0; i < NPIX; i++) applyStimulus(1'b1, 1'b1, 6'(i), BPP'($urandom), 1'b0);
    applyStimulus(1'b1, 1'b0, 6'd0, '0, 1'b1);
    idle(1'b1, FRAME_CLK + 8);

    // Grayscale ramp on row 0.
    for (int c = 0; c < COLS; c++) applyStimulus(1'b1, 1'b1, 6'(c), BPP'(gray[c]), 1'b0);
    applyStimulus(1'b1, 1'b0, 6'd0, '0, 1'b1);
    idle(1'b1, 2 * FRAME_CLK);

    // Swap requested at cycle 10 with writes continuing through the frame.
    waitPos(10);
    applyStimulus(1'b1, 1'b1, 6'($urandom_range(0, NPIX - 1)), BPP'($urandom), 1'b1);
    for (int i = 0; i < FRAME_CLK + 10; i++)
      applyStimulus(1'b1, 1'b1, 6'($urandom_range(0, NPIX - 1)), BPP'($urandom), 1'b0);

    // Write plus swap request exactly on the swap edge.
    applyStimulus(1'b1, 1'b0, 6'd0, '0, 1'b1);
    waitPos(FRAME_CLK - 1);
    applyStimulus(1'b1, 1'b1, 6'd3, 2'd3, 1'b1);
    idle(1'b1, 2 * FRAME_CLK + 4);

    // Out of range writes must not disturb the picture.
    applyStimulus(1'b1, 1'b1, 6'd36, 2'd3, 1'b0);
    applyStimulus(1'b1, 1'b1, 6'd63, 2'd2, 1'b0);
    applyStimulus(1'b1, 1'b0, 6'd0, '0, 1'b1);
    idle(1'b1, 2 * FRAME_CLK);

    // Drop enable mid row 3 for 5 cycles with a swap request and a write in between.
    waitPos(3 * ROW_CLK + 4);
    applyStimulus(1'b0, 1'b1, 6'd7, 2'd1, 1'b0);
    applyStimulus(1'b0, 1'b0, 6'd0, '0, 1'b1);
    idle(1'b0, 3);
    idle(1'b1, 2 * FRAME_CLK);

    // Reset mid-frame with a swap pending, released with the display enabled.
    applyStimulus(1'b1, 1'b0, 6'd0, '0, 1'b1);
    waitPos(20);
    doReset(3, 1'b1);
    idle(1'b1, 2 * FRAME_CLK);

    // Random traffic with occasional dark periods.
    for (int i = 0; i < 1500; i++) begin
      if (dark > 0) dark--;
      else if ($urandom_range(0, 299) == 0) dark = $urandom_range(1, 6);
      applyStimulus(dark == 0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 39)),
                    BPP'($urandom), $urandom_range(0, 39) == 0);
    end
    idle(1'b1, 4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
